// File: rtl/uart_autobaud_if.sv
// Host-side view of the auto-baud tick generator: the shared rx line, the calibration
// request, and the tick/status outputs.
interface uart_autobaud_if #(parameter int CNTW = 16);
  logic            rxpin;
  logic            autobaud;
  logic            bitxce;
  logic [CNTW-1:0] div;
  logic            locked;
  logic            calerr;
  logic            calbusy;

  modport master (output rxpin, autobaud, input bitxce, div, locked, calerr, calbusy);
  modport slave  (input rxpin, autobaud, output bitxce, div, locked, calerr, calbusy);
endinterface

// File: rtl/uart_autobaud.sv
// Subsample tick generator whose divisor is calibrated by timing a 0x55 sync character
// on rxpin. The four 2-bit intervals are cross-checked and their sum (8 bit times) sets div.
module uart_autobaud #(
  parameter int SUBDIV16   = 0,
  parameter int CNTW       = 16,
  parameter int DEFAULTDIV = 16
) (
  input logic            clk,
  input logic            rst_n,
  uart_autobaud_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNTW-1:0] ONES   = '1;
  localparam logic [CNTW-1:0] DEFDIV = CNTW'(DEFAULTDIV);
  localparam logic [CNTW:0]   RND    = (CNTW+1)'(SUBDIV16 != 0 ? 64 : 32);
  localparam int              SHIFT  = (SUBDIV16 != 0) ? 7 : 6;

  state_t          state;
  logic [2:0]      rx_pipe;   // [1:0] synchronizer, [2] previous sample for edge detect
  logic [CNTW-1:0] tcnt, div_q, saved_div, tot, ivl, ref_q;
  logic [1:0]      ecnt;
  logic            bitxce_q, locked_q, saved_locked, calerr_q, calbusy_q;

  logic            fall, last, sat_err, tol_err, fail;
  logic [CNTW-1:0] tot_inc, ivl_inc, newdiv;
  logic [CNTW:0]   tol_lo, tol_hi, rnd_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_pipe <= '1;
    else        rx_pipe <= {rx_pipe[1:0], bus.rxpin};
  end

  assign fall = rx_pipe[2] & ~rx_pipe[1];

  // Measurements use the post-increment counts so T8 is exactly the edge-to-edge distance.
  always_comb begin
    tot_inc = (tot == ONES) ? ONES : tot + CNTW'(1);
    ivl_inc = (ivl == ONES) ? ONES : ivl + CNTW'(1);
    tol_lo  = {1'b0, ref_q} - {1'b0, (ref_q >> 2)};
    tol_hi  = {1'b0, ref_q} + {1'b0, (ref_q >> 2)};
    rnd_sum = {1'b0, tot_inc} + RND;
    newdiv  = CNTW'(rnd_sum >> SHIFT);
    sat_err = (tot_inc == ONES) || (ivl_inc == ONES);
    tol_err = fall && (ecnt != 2'd0) &&
              (({1'b0, ivl_inc} < tol_lo) || ({1'b0, ivl_inc} > tol_hi));
    last    = fall && (ecnt == 2'd3);
    fail    = sat_err || tol_err || (last && (newdiv == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tcnt         <= DEFDIV;
      div_q        <= DEFDIV;
      saved_div    <= DEFDIV;
      tot          <= '0;
      ivl          <= '0;
      ref_q        <= '0;
      ecnt         <= '0;
      bitxce_q     <= 1'b0;
      locked_q     <= 1'b0;
      saved_locked <= 1'b0;
      calerr_q     <= 1'b0;
      calbusy_q    <= 1'b0;
    end else begin
      if (tcnt == CNTW'(1)) begin
        bitxce_q <= 1'b1;
        tcnt     <= div_q;
      end else begin
        bitxce_q <= 1'b0;
        tcnt     <= tcnt - CNTW'(1);
      end

      if (state == IDLE) begin
        if (bus.autobaud) begin
          state        <= ARM;
          calbusy_q    <= 1'b1;
          calerr_q     <= 1'b0;
          saved_div    <= div_q;
          saved_locked <= locked_q;
          locked_q     <= 1'b0;
        end
      end else if (bus.autobaud) begin
        // Restart keeps the divisor/lock captured by the original request.
        state <= ARM;
        tot   <= '0;
        ivl   <= '0;
        ecnt  <= '0;
      end else if (state == ARM) begin
        if (fall) begin
          state <= MEAS;
          tot   <= '0;
          ivl   <= '0;
          ecnt  <= '0;
        end
      end else begin
        tot <= tot_inc;
        ivl <= fall ? '0 : ivl_inc;
        if (fall) begin
          ecnt <= ecnt + 2'd1;
          if (ecnt == 2'd0) ref_q <= ivl_inc;
        end
        if (fail) begin
          state     <= IDLE;
          calerr_q  <= 1'b1;
          calbusy_q <= 1'b0;
          div_q     <= saved_div;
          locked_q  <= saved_locked;
        end else if (last) begin
          // Lock restarts the tick phase at the new rate.
          state     <= IDLE;
          calbusy_q <= 1'b0;
          div_q     <= newdiv;
          locked_q  <= 1'b1;
          tcnt      <= newdiv;
          bitxce_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.bitxce  = bitxce_q;
  assign bus.div     = div_q;
  assign bus.locked  = locked_q;
  assign bus.calerr  = calerr_q;
  assign bus.calbusy = calbusy_q;
endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: three instances (8 ticks/bit, 16 ticks/bit, 8-bit counters),
// a scoreboard of expected calibration outcomes checked whenever calbusy drops.
module tb_uart_autobaud;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] rx = '1;
  logic [2:0] ab = '0;
  always #5 clk = ~clk;

  uart_autobaud_if #(.CNTW(16)) if0 ();
  uart_autobaud_if #(.CNTW(16)) if1 ();
  uart_autobaud_if #(.CNTW(8))  if2 ();
  assign if0.rxpin = rx[0];  assign if0.autobaud = ab[0];
  assign if1.rxpin = rx[1];  assign if1.autobaud = ab[1];
  assign if2.rxpin = rx[2];  assign if2.autobaud = ab[2];

  uart_autobaud #(.SUBDIV16(0), .CNTW(16), .DEFAULTDIV(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  uart_autobaud #(.SUBDIV16(1), .CNTW(16), .DEFAULTDIV(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  uart_autobaud #(.SUBDIV16(0), .CNTW(8),  .DEFAULTDIV(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [2:0]  busy, bx, lk, ce;
  logic [15:0] dv [3];
  assign busy = {if2.calbusy, if1.calbusy, if0.calbusy};
  assign bx   = {if2.bitxce,  if1.bitxce,  if0.bitxce};
  assign lk   = {if2.locked,  if1.locked,  if0.locked};
  assign ce   = {if2.calerr,  if1.calerr,  if0.calerr};
  assign dv[0] = if0.div;
  assign dv[1] = if1.div;
  assign dv[2] = {8'h00, if2.div};

  int checks = 0;
  int errors = 0;
  int m_div [3] = '{16, 16, 16};
  int m_lk  [3] = '{0, 0, 0};
  int sub   [3] = '{0, 1, 0};
  int cw    [3] = '{16, 16, 8};

  typedef struct {int idx; int dv; int lk; int ce; int ok;} exp_t;
  exp_t scb[$];

  function automatic void chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ab(input int d);
    ab[d] = 1'b1;
    cyc(1);
    ab[d] = 1'b0;
    chk("calbusy_after_request", int'(busy[d]), 1);
  endtask

  // Reference: 2-bit intervals must stay within ref +/- floor(ref/4); the 8-bit-time total
  // is rounded to ticks; any overflow of the counter range or a zero divisor is an error.
  task automatic expect_cal(input int d, input int iv[4]);
    exp_t e;
    int sum, nd, ones, ok, dif;
    ones = (1 << cw[d]) - 1;
    sum  = iv[0] + iv[1] + iv[2] + iv[3];
    ok   = 1;
    for (int k = 1; k < 4; k++) begin
      dif = (iv[k] > iv[0]) ? iv[k] - iv[0] : iv[0] - iv[k];
      if (dif > iv[0] / 4) ok = 0;
    end
    if (sum >= ones) ok = 0;
    nd = (sub[d] != 0) ? (sum + 64) / 128 : (sum + 32) / 64;
    if (nd == 0) ok = 0;
    if (ok != 0) begin
      m_div[d] = nd;
      m_lk[d]  = 1;
    end
    e.idx = d; e.dv = m_div[d]; e.lk = m_lk[d]; e.ce = (ok != 0) ? 0 : 1; e.ok = ok;
    scb.push_back(e);
  endtask

  task automatic send_ivls(input int d, input int iv[4]);
    for (int k = 0; k < 4; k++) begin
      rx[d] = 1'b0; cyc(iv[k] / 2);
      rx[d] = 1'b1; cyc(iv[k] - iv[k] / 2);
    end
    rx[d] = 1'b0; cyc(iv[3] / 2);
    rx[d] = 1'b1; cyc(30);
  endtask

  task automatic calib(input int d, input int iv[4]);
    pulse_ab(d);
    cyc(8);
    expect_cal(d, iv);
    send_ivls(d, iv);
  endtask

  task automatic sync55(input int d, input int p);
    int iv[4];
    for (int k = 0; k < 4; k++) iv[k] = 2 * p;
    calib(d, iv);
  endtask

  task automatic chk_reset_outs(input int d);
    chk("reset_div", int'(dv[d]), 16);
    chk("reset_locked", int'(lk[d]), 0);
    chk("reset_calerr", int'(ce[d]), 0);
    chk("reset_calbusy", int'(busy[d]), 0);
    chk("reset_bitxce", int'(bx[d]), 0);
  endtask

  // Release reset and time the first two ticks (bounded window).
  task automatic tick_after_release;
    int f0, s0, f2, s2;
    f0 = -1; s0 = -1; f2 = -1; s2 = -1;
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      if (bx[0]) begin if (f0 < 0) f0 = k; else if (s0 < 0) s0 = k; end
      if (bx[2]) begin if (f2 < 0) f2 = k; else if (s2 < 0) s2 = k; end
    end
    chk("first_tick_dut0", f0, 16);
    chk("tick_period_dut0", s0 - f0, 16);
    chk("first_tick_dut2", f2, 16);
    chk("tick_period_dut2", s2 - f2, 16);
  endtask

  // Monitor: pop on every end of calibration; after a lock, the next two ticks are div apart.
  int pb [3] = '{0, 0, 0};
  int tw [3] = '{0, 0, 0};
  int tc [3] = '{0, 0, 0};
  int te [3] = '{0, 0, 0};
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        pb[i] = 0;
        tw[i] = 0;
      end else begin
        if (pb[i] != 0 && !busy[i]) begin
          if (scb.size() == 0) chk("unexpected_end", i, -1);
          else begin
            e = scb.pop_front();
            chk("end_dut_index", i, e.idx);
            chk("div", int'(dv[i]), e.dv);
            chk("locked", int'(lk[i]), e.lk);
            chk("calerr", int'(ce[i]), e.ce);
            if (e.ok != 0) begin tw[i] = 2; tc[i] = 0; te[i] = e.dv; end
          end
        end else if (tw[i] > 0) begin
          tc[i]++;
          if (bx[i]) begin
            chk("tick_spacing", tc[i], te[i]);
            tc[i] = 0;
            tw[i]--;
          end else if (tc[i] > te[i]) begin
            chk("tick_spacing", tc[i], te[i]);
            tw[i] = 0;
          end
        end
        pb[i] = int'(busy[i]);
      end
    end
  end

  initial begin
    int iv[4];
    int p;
    cyc(3);
    for (int d = 0; d < 3; d++) chk_reset_outs(d);
    tick_after_release();

    iv = '{128, 128, 170, 128};   // third interval beyond 160
    calib(0, iv);
    sync55(0, 3);                 // T8=24 -> zero divisor
    sync55(0, 64);
    sync55(0, 65);
    sync55(0, 68);
    sync55(1, 128);

    // Line stuck low on the 8-bit-counter instance.
    pulse_ab(2);
    cyc(8);
    scb.push_back('{idx: 2, dv: m_div[2], lk: m_lk[2], ce: 1, ok: 0});
    rx[2] = 1'b0; cyc(300);
    rx[2] = 1'b1; cyc(20);

    // Restart after the second edge, then a clean character.
    pulse_ab(0);
    cyc(8);
    rx[0] = 1'b0; cyc(64);
    rx[0] = 1'b1; cyc(64);
    rx[0] = 1'b0; cyc(20);
    pulse_ab(0);
    rx[0] = 1'b1; cyc(40);
    iv = '{128, 128, 128, 128};
    expect_cal(0, iv);
    send_ivls(0, iv);

    for (int n = 0; n < 8; n++) begin
      p = int'($urandom_range(4, 80));
      iv[0] = 2 * p;
      for (int k = 1; k < 4; k++) iv[k] = 2 * p + int'($urandom_range(0, p)) - p / 2;
      calib(n % 2, iv);
    end

    // Asynchronous reset in the middle of a measurement.
    pulse_ab(0);
    cyc(8);
    rx[0] = 1'b0; cyc(40);
    rx[0] = 1'b1; cyc(40);
    rx[0] = 1'b0; cyc(10);
    rst_n = 1'b0;
    #1;
    chk_reset_outs(0);
    for (int d = 0; d < 3; d++) begin m_div[d] = 16; m_lk[d] = 0; end
    cyc(2);
    rx[0] = 1'b1;
    tick_after_release();

    cyc(50);
    chk("scoreboard_drained", scb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog timeout got %0d want %0d", 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
